serial_comp_ctrl: RTL and testbench

//  Bit-serial magnitude-comparison controller that drives the 1-bit priority comparator cell
//  (inputs a,b,p1,p2,p3; outputs l1=less, l2=greater, l3=equal).

---
 rtl/serial_comp_ctrl_if.sv | 24 ++
 rtl/serial_comp_ctrl.sv | 114 +++++++++++
 tb/tb_serial_comp_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_comp_ctrl_if.sv
// Operand/result handshake between the operand source and the bit-serial
// comparison controller. The source is the master, the controller the slave.
interface serial_comp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, a_in, b_in,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparison controller.
// Feeds two WIDTH-bit operands MSB first into a 1-bit priority comparator
// cell, feeding the cell's less/greater result back as p1/p2 so the first
// differing bit locks the decision. Publishes lt/gt/eq with a done pulse.
// Optional build macro: EARLY_EXIT_EN -- finish as soon as the cell reports
// a decided result instead of always consuming all WIDTH bits.
module serial_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  serial_comp_ctrl_if.slave  bus,
  output logic               a_bit,
  output logic               b_bit,
  output logic               p1_o,
  output logic               p2_o,
  output logic               p3_o,
  input  logic               l1_i,
  input  logic               l2_i,
  input  logic               l3_i
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             lt_acc;
  logic             gt_acc;
  logic             last_bit;
  logic             running;

  assign running = (state == RUN);

`ifdef EARLY_EXIT_EN
  // Once the cell has decided, the remaining lower bits cannot change the outcome.
  assign last_bit = (cnt == '0) || l1_i || l2_i;
`else
  assign last_bit = (cnt == '0);
`endif

  // Cell drive: only meaningful while running, forced low otherwise.
  assign a_bit = running & sh_a[WIDTH-1];
  assign b_bit = running & sh_b[WIDTH-1];
  assign p1_o  = running & lt_acc;
  assign p2_o  = running & gt_acc;
  assign p3_o  = running & ~(lt_acc | gt_acc);

  // Control FSM with registered status/result outputs and operand shifters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      cnt      <= '0;
      lt_acc   <= 1'b0;
      gt_acc   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.lt   <= 1'b0;
      bus.gt   <= 1'b0;
      bus.eq   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a     <= bus.a_in;
            sh_b     <= bus.b_in;
            cnt      <= CNT_INIT;
            lt_acc   <= 1'b0;
            gt_acc   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          lt_acc <= l1_i;
          gt_acc <= l2_i;
          sh_a   <= sh_a << 1;
          sh_b   <= sh_b << 1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          if (last_bit) begin
            bus.lt   <= l1_i;
            bus.gt   <= l2_i;
            bus.eq   <= l3_i;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Testbench for serial_comp_ctrl: an 8-bit and a 1-bit instance, each wired
// to a behavioural model of the 1-bit priority comparator cell.
module tb_serial_comp_ctrl;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    int   lat;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       lt;
    logic       gt;
    logic       eq;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;

  logic a_bit8, b_bit8, p1_8, p2_8, p3_8, l1_8, l2_8, l3_8;
  logic a_bit1, b_bit1, p1_1, p2_1, p3_1, l1_1, l2_1, l3_1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  vec_t vecs[10];

  serial_comp_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_comp_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_comp_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .bus(bus8),
    .a_bit(a_bit8), .b_bit(b_bit8), .p1_o(p1_8), .p2_o(p2_8), .p3_o(p3_8),
    .l1_i(l1_8), .l2_i(l2_8), .l3_i(l3_8)
  );

  serial_comp_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .a_bit(a_bit1), .b_bit(b_bit1), .p1_o(p1_1), .p2_o(p2_1), .p3_o(p3_1),
    .l1_i(l1_1), .l2_i(l2_1), .l3_i(l3_1)
  );

  // Comparator cell: p1 (already less) beats p2 (already greater) beats the bit pair.
  assign l1_8 = p1_8 | (~p2_8 & ~a_bit8 & b_bit8);
  assign l2_8 = ~p1_8 & (p2_8 | (a_bit8 & ~b_bit8));
  assign l3_8 = ~l1_8 & ~l2_8;
  assign l1_1 = p1_1 | (~p2_1 & ~a_bit1 & b_bit1);
  assign l2_1 = ~p1_1 & (p2_1 | (a_bit1 & ~b_bit1));
  assign l3_1 = ~l1_1 & ~l2_1;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int expLatency(input logic [7:0] a, input logic [7:0] b);
`ifdef EARLY_EXIT_EN
    for (int i = 7; i >= 0; i--) begin
      if (a[i] !== b[i]) return (7 - i) + 2;
    end
`endif
    return 9;
  endfunction

  // Drives one start for a single cycle; afterwards the operand bus is scrambled.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic elt, input logic egt, input logic eeq,
                               input bit push);
    exp_t e;
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.start = 1'b1;
    if (push) begin
      e.lt  = elt;
      e.gt  = egt;
      e.eq  = eeq;
      e.lat = expLatency(a, b);
      sb_q.push_back(e);
    end
    tick();
    bus8.start = 1'b0;
    bus8.a_in  = 8'($urandom);
    bus8.b_in  = 8'($urandom);
  endtask

  task automatic checkResult(input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    checkOutput("res_lt", 32'(bus8.lt), 32'(e.lt));
    checkOutput("res_gt", 32'(bus8.gt), 32'(e.gt));
    checkOutput("res_eq", 32'(bus8.eq), 32'(e.eq));
    checkOutput("latency", 32'(cyc), 32'(e.lat));
  endtask

  // Full transaction on the 8-bit instance, ending in the first IDLE cycle after done.
  task automatic runVector(input logic [7:0] a, input logic [7:0] b,
                           input logic elt, input logic egt, input logic eeq);
    int cyc;
    bit busy_ok;
    applyStimulus(a, b, elt, egt, eeq, 1'b1);
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      if (bus8.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    if (bus8.done !== 1'b1) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      if (sb_q.size() != 0) sb_q.delete(0);
      return;
    end
    if (bus8.busy !== 1'b1) busy_ok = 1'b0;
    checkOutput("busy_run", 32'(busy_ok), 32'd1);
    checkResult(cyc);
    tick();
    checkOutput("done_pulse_busy", 32'({bus8.busy, bus8.done}), 32'd0);
  endtask

  task automatic runW1(input logic a, input logic b,
                       input logic elt, input logic egt, input logic eeq);
    bus1.a_in  = a;
    bus1.b_in  = b;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    checkOutput("w1_cycle1", 32'({bus1.busy, bus1.done}), 32'b10);
    tick();
    checkOutput("w1_done", 32'({bus1.busy, bus1.done}), 32'b11);
    checkOutput("w1_result", 32'({bus1.lt, bus1.gt, bus1.eq}), 32'({elt, egt, eeq}));
    tick();
    checkOutput("w1_after", 32'({bus1.busy, bus1.done}), 32'b00);
  endtask

  initial begin
    int         cyc;
    bit         ok;
    bit         p2_ok;
    logic [7:0] ra, rb;
    logic [7:0] a4, b4;
    logic [2:0] res4;

    vecs[0] = '{8'h35, 8'h35, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 8'hC2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0};

    rstn       = 1'b0;
    bus8.start = 1'b0;
    bus8.a_in  = '0;
    bus8.b_in  = '0;
    bus1.start = 1'b0;
    bus1.a_in  = '0;
    bus1.b_in  = '0;
    tick();
    tick();
    checkOutput("reset_state8", 32'({bus8.busy, bus8.done, bus8.lt, bus8.gt, bus8.eq,
                a_bit8, b_bit8, p1_8, p2_8, p3_8}), 32'd0);
    checkOutput("reset_state1", 32'({bus1.busy, bus1.done, bus1.lt, bus1.gt, bus1.eq,
                a_bit1, b_bit1, p1_1, p2_1, p3_1}), 32'd0);
    rstn = 1'b1;
    tick();

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      runVector(vecs[i].a, vecs[i].b, vecs[i].lt, vecs[i].gt, vecs[i].eq);
    end

    // Starts at cycles 3 and 9 must be ignored; result held until completion.
    $display("[TB] ignored starts while busy");
`ifdef EARLY_EXIT_EN
    a4 = 8'hA5; b4 = 8'hA5; res4 = 3'b001;
`else
    a4 = 8'h80; b4 = 8'h7F; res4 = 3'b010;
`endif
    applyStimulus(a4, b4, res4[2], res4[1], res4[0], 1'b1);
    ok    = 1'b1;
    p2_ok = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      if (c < 9) begin
        if (bus8.done !== 1'b0 || {bus8.lt, bus8.gt, bus8.eq} !== 3'b100) ok = 1'b0;
      end else begin
        checkOutput("ignore_done", 32'(bus8.done), 32'd1);
        if (bus8.done === 1'b1) checkResult(c);
      end
`ifndef EARLY_EXIT_EN
      if (c >= 2 && c <= 8 && p2_8 !== 1'b1) p2_ok = 1'b0;
      if (c == 1 && p2_8 !== 1'b0) p2_ok = 1'b0;
`endif
      bus8.start = (c == 3 || c == 9);
      if (c == 3) begin
        bus8.a_in = 8'h00;
        bus8.b_in = 8'hFF;
      end
      tick();
    end
    bus8.start = 1'b0;
    checkOutput("ignore_held", 32'(ok), 32'd1);
`ifndef EARLY_EXIT_EN
    checkOutput("p2_feedback", 32'(p2_ok), 32'd1);
`endif
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) ok = 1'b0;
      tick();
    end
    checkOutput("ignore_no_second", 32'(ok), 32'd1);

    // Reset in the middle of a run aborts it with no done.
    $display("[TB] reset mid-run");
    applyStimulus(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    checkOutput("midrun_reset", 32'({bus8.busy, bus8.done, bus8.lt, bus8.gt, bus8.eq,
                a_bit8, b_bit8, p1_8, p2_8, p3_8}), 32'd0);
    rstn = 1'b1;
    ok   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) ok = 1'b0;
      tick();
    end
    checkOutput("midrun_no_done", 32'(ok), 32'd1);
    runVector(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random vectors");
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      runVector(ra, rb, ra < rb, ra > rb, ra == rb);
    end

    $display("[TB] width-1 instance");
    runW1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    runW1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runW1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runW1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
